// File: rtl/ca_report_collector_pkg.sv
// rtl/ca_report_collector_pkg.sv - shared constants for the CA report collector
// Purpose: default parameter values and the record-width helper used by the
//          collector top and its report FIFO.
// Ports:   none (package).
package ca_report_collector_pkg;

  localparam int CA_DEPTH    = 8;
  localparam int CA_OFFSET_W = 16;
  localparam int CA_VEC_W    = 8;
  localparam int CA_RPT_LAT  = 1;

  // A record is {symbol offset, activation vector}.
  function automatic int ca_rec_w(input int offset_w, input int vec_w);
    return offset_w + vec_w;
  endfunction

  localparam int CA_REC_W = ca_rec_w(CA_OFFSET_W, CA_VEC_W);

endpackage

// File: rtl/ca_report_fifo.sv
// rtl/ca_report_fifo.sv - synchronous report FIFO with occupancy counter
// Purpose: stores report records; a push is accepted when not full, or when
//          full and a pop happens in the same cycle.
// Ports:   clk, rst       - clock, synchronous active-high reset
//          push_i, data_i - write request and record
//          pop_i          - read request (ignored when empty)
//          data_o         - head record
//          full_o, empty_o, level_o - occupancy status
module ca_report_fifo
  import ca_report_collector_pkg::*;
#(
  parameter int DEPTH = CA_DEPTH,
  parameter int W     = CA_REC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  // When full, the slot being popped is the one the write pointer targets,
  // so a simultaneous push lands behind every surviving entry.
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ca_report_collector.sv
// rtl/ca_report_collector.sv - tags CA report bits with symbol offsets and queues them
// Purpose: counts accepted symbols, delays (valid, offset) to line up with the
//          CA processor's report bit, and queues {offset, act_vec} records.
// Ports:   clk, rst                   - clock, synchronous active-high reset
//          sym_valid                  - symbol fed to the CA processor
//          rpt_bit, act_vec           - report bit and activation vector
//          rec_ready                  - downstream accepts head record
//          rec_valid, rec_offset, rec_vector - head record
//          level                      - FIFO occupancy
//          overflow, drop_cnt         - sticky drop flag, saturating drop count
module ca_report_collector
  import ca_report_collector_pkg::*;
#(
  parameter int DEPTH    = CA_DEPTH,
  parameter int OFFSET_W = CA_OFFSET_W,
  parameter int VEC_W    = CA_VEC_W,
  parameter int RPT_LAT  = CA_RPT_LAT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sym_valid,
  input  logic                   rpt_bit,
  input  logic [VEC_W-1:0]       act_vec,
  input  logic                   rec_ready,
  output logic                   rec_valid,
  output logic [OFFSET_W-1:0]    rec_offset,
  output logic [VEC_W-1:0]       rec_vector,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [7:0]             drop_cnt
);

  localparam int REC_W = ca_rec_w(OFFSET_W, VEC_W);

  logic [OFFSET_W-1:0] cnt_q, cnt_d;
  logic                dly_valid_q  [RPT_LAT];
  logic [OFFSET_W-1:0] dly_offset_q [RPT_LAT];
  logic                overflow_q, overflow_d;
  logic [7:0]          drop_cnt_q, drop_cnt_d;

  logic                push_req, pop_req, drop;
  logic                fifo_full, fifo_empty;
  logic [REC_W-1:0]    fifo_data;

  // A report only counts if it lines up with a real symbol RPT_LAT cycles ago.
  assign push_req = rpt_bit & dly_valid_q[RPT_LAT-1];
  assign pop_req  = rec_ready & ~fifo_empty;
  assign drop     = push_req & fifo_full & ~pop_req;

  always_comb begin
    cnt_d      = sym_valid ? cnt_q + OFFSET_W'(1) : cnt_q;
    overflow_d = overflow_q | drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      for (int i = 0; i < RPT_LAT; i++) begin
        dly_valid_q[i]  <= 1'b0;
        dly_offset_q[i] <= '0;
      end
    end else begin
      cnt_q           <= cnt_d;
      overflow_q      <= overflow_d;
      drop_cnt_q      <= drop_cnt_d;
      // Stage 0 captures the pre-increment count of this cycle's symbol.
      dly_valid_q[0]  <= sym_valid;
      dly_offset_q[0] <= cnt_q;
      for (int i = 1; i < RPT_LAT; i++) begin
        dly_valid_q[i]  <= dly_valid_q[i-1];
        dly_offset_q[i] <= dly_offset_q[i-1];
      end
    end
  end

  ca_report_fifo #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_req),
    .data_i  ({dly_offset_q[RPT_LAT-1], act_vec}),
    .pop_i   (rec_ready),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  assign rec_valid  = ~fifo_empty;
  assign rec_offset = fifo_data[REC_W-1:VEC_W];
  assign rec_vector = fifo_data[VEC_W-1:0];
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_cnt_q;

endmodule
